// File: rtl/rv_branch_unit_bht.sv
// -----------------------------------------------------------------------------
// rv_branch_unit_bht
//
// Execute-stage branch resolution unit with an integrated bimodal branch
// history table (BHT) of 2-bit saturating counters.
//
// The unit resolves conditional branches, JAL and JALR. It computes the
// target and link address, compares the outcome with what fetch predicted,
// and issues a registered redirect when fetch got it wrong. The BHT supplies
// a combinational direction prediction for the fetch PC and is trained only
// by resolved conditional branches.
//
// Ports
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   pred_pc         fetch PC to predict
//   pred_taken      combinational prediction (MSB of the indexed counter)
//   ex_valid        execute-stage instruction valid
//   ex_pc           PC of the execute instruction
//   rs1_value       operand 1
//   rs2_value       operand 2
//   imm_value       sign-extended B/J/I immediate
//   funct3          branch condition
//   branch_op       conditional branch
//   jal_op          JAL
//   jalr_op         JALR
//   ex_pred_taken   direction fetch used for this instruction
//   ex_pred_target  target fetch used when ex_pred_taken=1
//   stall           hold all state
//   flush           kill the execute instruction
//   res_valid       registered: a control-flow instruction resolved
//   res_taken       registered actual direction
//   res_target      registered computed target
//   link_value      registered ex_pc+4 (rd value for JAL/JALR)
//   redirect_valid  registered mispredict pulse
//   redirect_pc     registered correct next PC
//   misalign_exc    registered instruction-address-misaligned exception
// -----------------------------------------------------------------------------
module rv_branch_unit_bht #(
    parameter int          XLEN          = 32,
    parameter int          BHT_ENTRIES   = 64,
    parameter logic [1:0]  BHT_RESET_CTR = 2'b01,
    parameter int          ALIGN_BITS    = 2
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,

    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [XLEN-1:0] imm_value,
    input  logic [2:0]      funct3,
    input  logic            branch_op,
    input  logic            jal_op,
    input  logic            jalr_op,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            stall,
    input  logic            flush,

    output logic            res_valid,
    output logic            res_taken,
    output logic [XLEN-1:0] res_target,
    output logic [XLEN-1:0] link_value,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign_exc
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] pred_idx;
    logic [IDX-1:0] ex_idx;
    logic [1:0]     ex_ctr;
    logic [1:0]     ex_ctr_next;

    assign pred_idx = pred_pc[IDX+1:2];
    assign ex_idx   = ex_pc[IDX+1:2];

    // Reading the array directly gives the pre-update value when fetch and
    // execute hit the same entry in the same cycle.
    assign pred_taken = bht[pred_idx][1];
    assign ex_ctr     = bht[ex_idx];

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
    logic cond;
    logic taken;

    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000:  cond = (rs1_value == rs2_value);
            3'b001:  cond = (rs1_value != rs2_value);
            3'b100:  cond = ($signed(rs1_value) <  $signed(rs2_value));
            3'b101:  cond = ($signed(rs1_value) >= $signed(rs2_value));
            3'b110:  cond = (rs1_value <  rs2_value);
            3'b111:  cond = (rs1_value >= rs2_value);
            default: cond = 1'b0;
        endcase
    end

    assign taken = jal_op | jalr_op | (branch_op & cond);

    // ------------------------------------------------------------------
    // Target, link and mispredict detection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_rel_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            misalign;
    logic            mispredict;
    logic            resolve;
    logic            train;

    assign jalr_sum      = rs1_value + imm_value;
    assign pc_rel_target = ex_pc + imm_value;
    assign target        = jalr_op ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_target;
    assign link          = ex_pc + XLEN'(4);

    assign misalign   = taken & (target[ALIGN_BITS-1:0] != '0);
    assign mispredict = (taken != ex_pred_taken)
                      | (taken & ex_pred_taken & (target != ex_pred_target));

    assign resolve = ex_valid & (branch_op | jal_op | jalr_op) & ~stall & ~flush;
    assign train   = resolve & branch_op;

    always_comb begin
        ex_ctr_next = ex_ctr;
        if (taken) begin
            if (ex_ctr != 2'b11) begin
                ex_ctr_next = ex_ctr + 2'b01;
            end
        end else begin
            if (ex_ctr != 2'b00) begin
                ex_ctr_next = ex_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= BHT_RESET_CTR;
            end
        end else if (train) begin
            bht[ex_idx] <= ex_ctr_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered resolution outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_target     <= '0;
            link_value     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign_exc   <= 1'b0;
        end else if (!stall) begin
            // Pulses drop on any non-resolving cycle; data holds its last value.
            res_valid      <= resolve;
            redirect_valid <= resolve & mispredict & ~misalign;
            misalign_exc   <= resolve & misalign;
            if (resolve) begin
                res_taken   <= taken;
                res_target  <= target;
                link_value  <= link;
                redirect_pc <= taken ? target : link;
            end
        end
    end

    // Fetch PC bits outside the index and the dropped JALR LSB are not needed.
    logic unused_bits;
    assign unused_bits = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_rv_branch_unit_bht.sv
module tb_rv_branch_unit_bht;

    logic        clk;
    logic        reset_n;
    logic [31:0] pred_pc;
    logic        ex_valid;
    logic [31:0] ex_pc, rs1_value, rs2_value, imm_value;
    logic [2:0]  funct3;
    logic        branch_op, jal_op, jalr_op, ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        stall, flush;

    // main instance (defaults)
    logic        pred_taken, res_valid, res_taken, redirect_valid, misalign_exc;
    logic [31:0] res_target, link_value, redirect_pc;
    // reset-counter variant
    logic        r2_pred, r2_rv, r2_rt, r2_rdv, r2_mis;
    logic [31:0] r2_tgt, r2_lnk, r2_rpc;
    // ALIGN_BITS=1 variant
    logic        a1_pred, a1_rv, a1_rt, a1_rdv, a1_mis;
    logic [31:0] a1_tgt, a1_lnk, a1_rpc;

    rv_branch_unit_bht u_dut (
        .clk(clk), .reset_n(reset_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .imm_value(imm_value), .funct3(funct3), .branch_op(branch_op), .jal_op(jal_op),
        .jalr_op(jalr_op), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .stall(stall), .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
        .res_target(res_target), .link_value(link_value), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .misalign_exc(misalign_exc)
    );

    rv_branch_unit_bht #(.BHT_RESET_CTR(2'b10)) u_r2 (
        .clk(clk), .reset_n(reset_n), .pred_pc(pred_pc), .pred_taken(r2_pred),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .imm_value(imm_value), .funct3(funct3), .branch_op(branch_op), .jal_op(jal_op),
        .jalr_op(jalr_op), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .stall(stall), .flush(flush), .res_valid(r2_rv), .res_taken(r2_rt),
        .res_target(r2_tgt), .link_value(r2_lnk), .redirect_valid(r2_rdv),
        .redirect_pc(r2_rpc), .misalign_exc(r2_mis)
    );

    rv_branch_unit_bht #(.ALIGN_BITS(1)) u_a1 (
        .clk(clk), .reset_n(reset_n), .pred_pc(pred_pc), .pred_taken(a1_pred),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .imm_value(imm_value), .funct3(funct3), .branch_op(branch_op), .jal_op(jal_op),
        .jalr_op(jalr_op), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .stall(stall), .flush(flush), .res_valid(a1_rv), .res_taken(a1_rt),
        .res_target(a1_tgt), .link_value(a1_lnk), .redirect_valid(a1_rdv),
        .redirect_pc(a1_rpc), .misalign_exc(a1_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, taken;
        logic [31:0] target, link;
        logic        redir;
        logic [31:0] rpc;
        logic        mis, mis_a1, pred;
    } exp_t;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [2:0]  f3;
        logic        br, jal, jalr, pt;
        logic [31:0] ptgt;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] f3,
        input logic br, jal, jalr, pt, input logic [31:0] ptgt,
        input logic v, t, input logic [31:0] tgt, lnk, input logic rd,
        input logic [31:0] rpc, input logic mis, ma1, pred);
        vec_t r;
        r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.f3 = f3;
        r.br = br; r.jal = jal; r.jalr = jalr; r.pt = pt; r.ptgt = ptgt;
        r.e.v = v; r.e.taken = t; r.e.target = tgt; r.e.link = lnk;
        r.e.redir = rd; r.e.rpc = rpc; r.e.mis = mis; r.e.mis_a1 = ma1; r.e.pred = pred;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_in(input logic ev, input logic stl, input logic fl,
                            input logic [31:0] ppc, input vec_t vv);
        @(negedge clk);
        pred_pc        = ppc;
        ex_valid       = ev;
        stall          = stl;
        flush          = fl;
        ex_pc          = vv.pc;
        rs1_value      = vv.rs1;
        rs2_value      = vv.rs2;
        imm_value      = vv.imm;
        funct3         = vv.f3;
        branch_op      = vv.br;
        jal_op         = vv.jal;
        jalr_op        = vv.jalr;
        ex_pred_taken  = vv.pt;
        ex_pred_target = vv.ptgt;
        exp_q.push_back(vv.e);
    endtask

    task automatic wait_out(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: queue empty, got 0 expected 1 entries", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " res_valid"},      32'(res_valid),      32'(e.v));
            chk({tag, " res_taken"},      32'(res_taken),      32'(e.taken));
            chk({tag, " res_target"},     res_target,          e.target);
            chk({tag, " link_value"},     link_value,          e.link);
            chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'(e.redir));
            chk({tag, " redirect_pc"},    redirect_pc,         e.rpc);
            chk({tag, " misalign_exc"},   32'(misalign_exc),   32'(e.mis));
            chk({tag, " misalign_a1"},    32'(a1_mis),         32'(e.mis_a1));
            chk({tag, " pred_taken"},     32'(pred_taken),     32'(e.pred));
        end
    endtask

    task automatic step(input string tag, input logic ev, input logic stl, input logic fl,
                        input logic [31:0] ppc, input vec_t vv);
        drive_in(ev, stl, fl, ppc, vv);
        wait_out(tag);
    endtask

    vec_t tbl [12];
    vec_t bne_t, bne_nt, idle;

    initial begin
        // pc rs1 rs2 imm f3 br jal jalr pt ptgt | v t target link redir rpc mis mis_a1 pred(0x40)
        tbl[0]  = mk(32'h40, 32'd5, 32'd5, 32'h20, 3'b000, 1,0,0, 0, 32'h0,
                     1,1, 32'h60, 32'h44, 1, 32'h60, 0,0, 1);
        tbl[1]  = mk(32'h50, 32'hFFFFFFFF, 32'd1, 32'h10, 3'b100, 1,0,0, 1, 32'h60,
                     1,1, 32'h60, 32'h54, 0, 32'h60, 0,0, 1);
        tbl[2]  = mk(32'h70, 32'hFFFFFFFF, 32'd1, 32'h10, 3'b110, 1,0,0, 1, 32'h80,
                     1,0, 32'h80, 32'h74, 1, 32'h74, 0,0, 1);
        tbl[3]  = mk(32'h80, 32'h1001, 32'd0, 32'd2, 3'b000, 0,0,1, 1, 32'h1002,
                     1,1, 32'h1002, 32'h84, 0, 32'h1002, 1,0, 1);
        tbl[4]  = mk(32'h80, 32'h1001, 32'd0, 32'd4, 3'b000, 0,0,1, 1, 32'h1002,
                     1,1, 32'h1004, 32'h84, 1, 32'h1004, 0,0, 1);
        tbl[5]  = mk(32'h90, 32'd0, 32'd0, 32'd6, 3'b000, 0,1,0, 0, 32'h0,
                     1,1, 32'h96, 32'h94, 0, 32'h96, 1,0, 1);
        tbl[6]  = mk(32'hA0, 32'd1, 32'd2, 32'hFFFFFFF8, 3'b001, 1,0,0, 0, 32'h0,
                     1,1, 32'h98, 32'hA4, 1, 32'h98, 0,0, 1);
        tbl[7]  = mk(32'hB0, 32'hFFFFFFFB, 32'd3, 32'h100, 3'b101, 1,0,0, 0, 32'h0,
                     1,0, 32'h1B0, 32'hB4, 0, 32'hB4, 0,0, 1);
        tbl[8]  = mk(32'hC0, 32'hFFFFFFFB, 32'd3, 32'h100, 3'b111, 1,0,0, 0, 32'h0,
                     1,1, 32'h1C0, 32'hC4, 1, 32'h1C0, 0,0, 1);
        tbl[9]  = mk(32'hD0, 32'd0, 32'd0, 32'd8, 3'b010, 1,0,0, 1, 32'hD8,
                     1,0, 32'hD8, 32'hD4, 1, 32'hD4, 0,0, 1);
        tbl[10] = mk(32'hFFFFFFFC, 32'd0, 32'd0, 32'h14, 3'b000, 0,1,0, 1, 32'h10,
                     1,1, 32'h10, 32'h0, 0, 32'h10, 0,0, 1);
        tbl[11] = mk(32'h40, 32'd5, 32'd6, 32'h20, 3'b000, 1,0,0, 0, 32'h0,
                     1,0, 32'h60, 32'h44, 0, 32'h44, 0,0, 0);

        // reset: all inputs idle, outputs must be zero, counters at reset value
        reset_n = 1'b0;
        pred_pc = 32'h100; ex_valid = 0; ex_pc = 0; rs1_value = 0; rs2_value = 0;
        imm_value = 0; funct3 = 0; branch_op = 0; jal_op = 0; jalr_op = 0;
        ex_pred_taken = 0; ex_pred_target = 0; stall = 0; flush = 0;
        #12;
        chk("reset res_valid",      32'(res_valid),      32'd0);
        chk("reset res_target",     res_target,          32'd0);
        chk("reset link_value",     link_value,          32'd0);
        chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
        chk("reset redirect_pc",    redirect_pc,         32'd0);
        chk("reset misalign_exc",   32'(misalign_exc),   32'd0);
        chk("reset pred_taken",     32'(pred_taken),     32'd0);
        chk("reset pred_taken ctr10", 32'(r2_pred),      32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // pre-training check of the 0x40 entry
        idle = mk(32'h0, 0, 0, 0, 3'b000, 0,0,0, 0, 0,
                  0,0, 32'h0, 32'h0, 0, 32'h0, 0,0, 0);
        step("idle0", 1'b1, 1'b0, 1'b0, 32'h40, idle);

        for (int i = 0; i < 12; i++) begin
            step($sformatf("vec%0d", i), 1'b1, 1'b0, 1'b0, 32'h40, tbl[i]);
        end

        // non-resolve cycle at a fresh entry: pulses drop, data holds
        idle = mk(32'h0, 0, 0, 0, 3'b000, 0,0,0, 0, 0,
                  0,0, 32'h60, 32'h44, 0, 32'h44, 0,0, 0);
        step("hold_idle", 1'b0, 1'b0, 1'b0, 32'h200, idle);

        // four taken BNEs at 0x200: counter 01 -> 10 -> 11 -> 11 -> 11
        bne_t = mk(32'h200, 32'd1, 32'd2, 32'h10, 3'b001, 1,0,0, 1, 32'h210,
                   1,1, 32'h210, 32'h204, 0, 32'h210, 0,0, 1);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("bne_t%0d", i), 1'b1, 1'b0, 1'b0, 32'h200, bne_t);
        end

        // stall with a would-be mispredicting not-taken BNE: everything holds
        bne_nt = mk(32'h200, 32'd3, 32'd3, 32'h10, 3'b001, 1,0,0, 1, 32'h210,
                    1,1, 32'h210, 32'h204, 0, 32'h210, 0,0, 1);
        step("stall", 1'b1, 1'b1, 1'b0, 32'h200, bne_nt);

        // flush: valids clear, data holds, no training
        bne_nt.e.v = 1'b0;
        step("flush", 1'b1, 1'b0, 1'b1, 32'h200, bne_nt);

        // not-taken: 11 -> 10 (still predicts taken only if it saturated at 11)
        bne_nt = mk(32'h200, 32'd3, 32'd3, 32'h10, 3'b001, 1,0,0, 0, 32'h0,
                    1,0, 32'h210, 32'h204, 0, 32'h204, 0,0, 1);
        step("bne_nt0", 1'b1, 1'b0, 1'b0, 32'h200, bne_nt);

        // second not-taken with same-index read: pre-update value visible
        bne_nt.e.pred = 1'b0;
        drive_in(1'b1, 1'b0, 1'b0, 32'h200, bne_nt);
        #1;
        chk("collision pre-update pred", 32'(pred_taken), 32'd1);
        wait_out("bne_nt1");

        idle = mk(32'h0, 0, 0, 0, 3'b000, 0,0,0, 0, 0,
                  0,0, 32'h210, 32'h204, 0, 32'h204, 0,0, 0);
        step("idle_end", 1'b0, 1'b0, 1'b0, 32'h200, idle);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d expected 0 entries", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_branch_unit_bht.md
Name: rv_branch_unit_bht

Overview:
Parametrised branch resolution unit for the execute stage. It evaluates conditional branches, JAL and JALR, and computes the target and link address. It compares the outcome against the fetch-stage prediction and issues a registered redirect on misprediction. It also owns a bimodal branch history table (BHT) of 2-bit saturating counters, which supplies direction predictions to fetch and is trained by resolved conditional branches.

Parameters:
XLEN, 32, datapath/address width (32 or 64)
BHT_ENTRIES, 64, number of 2-bit counters; power of 2, minimum 2
BHT_RESET_CTR, 2'b01, counter value after reset (weakly not-taken)
ALIGN_BITS, 2, required target alignment in bits (2 = RV32I, 1 = C extension)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
pred_pc  in  XLEN  fetch PC to predict
pred_taken  out  1  combinational prediction: MSB of counter[pred_pc index]
ex_valid  in  1  execute-stage instruction valid
ex_pc  in  XLEN  PC of the execute instruction
rs1_value  in  XLEN  operand 1
rs2_value  in  XLEN  operand 2
imm_value  in  XLEN  sign-extended B/J/I immediate
funct3  in  3  branch condition
branch_op  in  1  conditional branch
jal_op  in  1  JAL
jalr_op  in  1  JALR
ex_pred_taken  in  1  direction fetch used for this instruction
ex_pred_target  in  XLEN  target fetch used when ex_pred_taken=1
stall  in  1  hold all state
flush  in  1  kill the execute instruction
res_valid  out  1  registered: a control-flow instruction resolved
res_taken  out  1  registered actual direction
res_target  out  XLEN  registered computed target
link_value  out  XLEN  registered ex_pc+4, the rd value for JAL/JALR
redirect_valid  out  1  registered mispredict pulse
redirect_pc  out  XLEN  registered correct next PC
misalign_exc  out  1  registered instruction-address-misaligned exception

Behaviour:
- Reset (reset_n=0, asynchronous): all registered outputs go to 0 and every BHT counter goes to BHT_RESET_CTR.
- BHT index: pc[IDX+1:2], where IDX = log2(BHT_ENTRIES). pred_taken is purely combinational.
- Conditions:
  - 000 EQ, 001 NE.
  - 100 signed LT, 101 signed GE.
  - 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 give not-taken.
- Actual taken = jal_op | jalr_op | (branch_op & cond).
- Target, computed at full XLEN with wrap-around modulo 2^XLEN:
  - JALR: (rs1+imm) with bit0 cleared.
  - Otherwise: ex_pc+imm.
- Resolve event: ex_valid & (branch_op|jal_op|jalr_op) & !stall & !flush.
- One-cycle latency. On a resolve event the outputs register at the next edge:
  - res_valid=1, res_taken, res_target, link_value.
  - misalign_exc = taken & (target[ALIGN_BITS-1:0]!=0).
  - mispredict = (taken != ex_pred_taken) | (taken & ex_pred_taken & target != ex_pred_target).
  - redirect_valid = mispredict & !misalign_exc.
  - redirect_pc = taken ? target : ex_pc+4.
- Non-resolve, non-stall cycle: res_valid, redirect_valid and misalign_exc go to 0. Data outputs hold.
- stall=1: every output and the BHT hold. stall takes priority over ex_valid.
- flush=1 (and stall=0): valid and exception outputs clear next cycle, and the BHT is not updated. flush takes priority over ex_valid.
- BHT training applies on resolve events with branch_op=1 only:
  - taken: counter+1, saturating at 3.
  - not taken: counter-1, saturating at 0.
  - JAL/JALR never train.
- Read/write collision: when pred_pc and ex_pc map to the same index in the same cycle, pred_taken returns the pre-update value.
- Aliasing between PCs that share an index is permitted.
- Simultaneous flags: ex_valid with none of branch_op/jal_op/jalr_op is a non-event. More than one op flag set is illegal; the bench must not drive it.

Test Plan:
1. Reset, then pred_pc=0x100 → pred_taken=0. Every index reads 01; check via BHT_RESET_CTR=2'b10 variant → pred_taken=1.
2. BEQ at ex_pc=0x40, rs1=rs2=5, imm=0x20, ex_pred_taken=0 → next cycle res_taken=1, res_target=0x60, redirect_valid=1, redirect_pc=0x60; counter[0x40 index] 01→10.
3. BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken. With ex_pred_taken=1 on the BLTU → redirect_pc=ex_pc+4.
4. JALR rs1=0x1001, imm=2, ex_pc=0x80, ex_pred_taken=1, ex_pred_target=0x1002 → target=0x1002, no redirect, link_value=0x84, BHT unchanged. Same instruction with imm=4 → target=0x1004, redirect_valid=1.
5. JAL with imm=6, ALIGN_BITS=2 → misalign_exc=1, redirect_valid=0. Same with ALIGN_BITS=1 → no exception.
6. Four taken BNEs at one PC → counter saturates at 3. Then a stall cycle with ex_valid=1 → outputs held and counter unchanged. Then a flush with ex_valid=1 → res_valid=0 and no counter change.
